// File: rtl/fpu_div_seq.sv
// Multi-cycle IEEE-754 divider: radix-2 restoring iteration, one quotient bit per cycle,
// four rounding modes, flush-to-zero on input and output, valid/ready on both sides.
module fpu_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   i_clk,
  input  logic                   i_rsn,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_op1,
  input  logic [EXP_W+MAN_W:0]   i_op2,
  input  logic [1:0]             i_rm,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [EXP_W+MAN_W:0]   o_res,
  output logic [4:0]             o_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int Q    = MAN_W + 3;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(Q);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam logic signed [EW-1:0] LP_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] LP_EMAX = EW'((2**EXP_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RND, S_DONE} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_sign;
  logic [1:0]             r_rm;
  logic signed [EW-1:0]   r_exp;
  logic [MAN_W+1:0]       r_rem;
  logic [MAN_W+1:0]       r_div;
  logic [Q-1:0]           r_quo;
  logic [W-1:0]           r_res;
  logic [4:0]             r_flags;
  logic                   r_valid;
  logic                   r_ready;

  // Operand classification, resolved combinationally at accept
  logic [EXP_W-1:0] w_e1, w_e2;
  logic [MAN_W-1:0] w_m1, w_m2;
  logic w_max1, w_max2, w_zero1, w_zero2;
  logic w_nan1, w_nan2, w_inf1, w_inf2;
  logic w_special, w_inSign;
  logic signed [EW-1:0] w_expInit;
  logic [W-1:0] w_spRes;
  logic [4:0]   w_spFlags;

  assign w_e1      = i_op1[W-2:MAN_W];
  assign w_e2      = i_op2[W-2:MAN_W];
  assign w_m1      = i_op1[MAN_W-1:0];
  assign w_m2      = i_op2[MAN_W-1:0];
  assign w_max1    = &w_e1;
  assign w_max2    = &w_e2;
  assign w_zero1   = ~|w_e1;
  assign w_zero2   = ~|w_e2;
  assign w_nan1    = w_max1 & (|w_m1);
  assign w_nan2    = w_max2 & (|w_m2);
  assign w_inf1    = w_max1 & ~(|w_m1);
  assign w_inf2    = w_max2 & ~(|w_m2);
  assign w_special = w_max1 | w_max2 | w_zero1 | w_zero2;
  assign w_inSign  = i_op1[W-1] ^ i_op2[W-1];
  assign w_expInit = $signed({2'b00, w_e1}) - $signed({2'b00, w_e2}) + LP_BIAS;

  always_comb begin
    w_spRes   = '0;
    w_spFlags = '0;
    if (w_nan1 | w_nan2 | (w_zero1 & w_zero2) | (w_inf1 & w_inf2)) begin
      w_spRes      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_spFlags[4] = 1'b1;
    end else if (w_inf1) begin
      w_spRes = {w_inSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_zero2) begin
      w_spRes      = {w_inSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spFlags[3] = 1'b1;
    end else begin
      w_spRes = {w_inSign, {(W-1){1'b0}}};
    end
  end

  logic             w_ge;
  logic [MAN_W+1:0] w_remSub;

  assign w_ge     = (r_rem >= r_div);
  assign w_remSub = w_ge ? (r_rem - r_div) : r_rem;

  // Normalisation drops the leading one; a quotient below 1 borrows one exponent step
  logic [Q-2:0]         w_normLo;
  logic                 w_guard, w_round, w_sticky, w_lsb, w_inexact, w_inc, w_carry, w_toInf;
  logic [MAN_W-1:0]     w_fracR;
  logic signed [EW-1:0] w_eNorm, w_eFin;
  logic [W-1:0]         w_rndRes;
  logic [4:0]           w_rndFlags;

  assign w_normLo  = r_quo[Q-1] ? r_quo[Q-2:0] : {r_quo[Q-3:0], 1'b0};
  assign w_guard   = w_normLo[1];
  assign w_round   = w_normLo[0];
  assign w_sticky  = |r_rem;
  assign w_lsb     = w_normLo[2];
  assign w_inexact = w_guard | w_round | w_sticky;
  assign w_toInf   = (r_rm == 2'd0) | ((r_rm == 2'd3) & ~r_sign) | ((r_rm == 2'd2) & r_sign);

  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      2'd0:    w_inc = w_guard & (w_round | w_sticky | w_lsb);
      2'd1:    w_inc = 1'b0;
      2'd2:    w_inc = r_sign & w_inexact;
      default: w_inc = ~r_sign & w_inexact;
    endcase
  end

  assign w_fracR = w_normLo[Q-2:2] + {{(MAN_W-1){1'b0}}, w_inc};
  assign w_carry = w_inc & (&w_normLo[Q-2:2]);
  assign w_eNorm = r_exp - $signed({{(EW-1){1'b0}}, ~r_quo[Q-1]});
  assign w_eFin  = w_eNorm + $signed({{(EW-1){1'b0}}, w_carry});

  always_comb begin
    w_rndRes   = {r_sign, w_eFin[EXP_W-1:0], w_fracR};
    w_rndFlags = {4'b0000, w_inexact};
    if (w_eFin >= LP_EMAX) begin
      w_rndFlags = 5'b00101;
      w_rndRes   = w_toInf ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                           : {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else if (w_eFin[EW-1] || (w_eFin == '0)) begin
      w_rndFlags = 5'b00011;
      w_rndRes   = {r_sign, {(W-1){1'b0}}};
    end
  end

  // Flush outranks both accept and the result handshake
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_rm    <= 2'd0;
      r_exp   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_quo   <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_ready <= 1'b0;
            r_rm    <= i_rm;
            r_sign  <= w_inSign;
            if (w_special) begin
              r_res   <= w_spRes;
              r_flags <= w_spFlags;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_flags <= '0;
              r_rem   <= {1'b0, 1'b1, w_m1};
              r_div   <= {1'b0, 1'b1, w_m2};
              r_exp   <= w_expInit;
              r_quo   <= '0;
              r_cnt   <= '0;
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_quo <= {r_quo[Q-2:0], w_ge};
          r_rem <= w_remSub << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(Q-1)) r_state <= S_RND;
        end
        S_RND: begin
          r_res   <= w_rndRes;
          r_flags <= w_rndFlags;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_res   = r_res;
  assign o_flags = r_flags;

endmodule

// File: tb/tb_fpu_div_seq.sv
// Directed bench for fpu_div_seq: single-precision and half-precision instances,
// scoreboard queue of expected results popped when each result appears.
module tb_fpu_div_seq;

  logic        clk;
  logic        rsn;
  logic        flush, iValid, iReady, oReady, oValid;
  logic [31:0] op1, op2, oRes;
  logic [1:0]  rm;
  logic [4:0]  oFlags;

  logic        hFlush, hValid, hIReady, hOReady, hOValid;
  logic [15:0] hOp1, hOp2, hRes;
  logic [1:0]  hRm;
  logic [4:0]  hFlags;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t dropped;
  int   nAssert = 0;
  int   nFail   = 0;
  int   sawValid;

  fpu_div_seq dut (
    .i_clk(clk), .i_rsn(rsn), .i_flush(flush), .i_valid(iValid), .o_ready(oReady),
    .i_op1(op1), .i_op2(op2), .i_rm(rm), .o_valid(oValid), .i_ready(iReady),
    .o_res(oRes), .o_flags(oFlags)
  );

  fpu_div_seq #(.EXP_W(5), .MAN_W(10)) dutHalf (
    .i_clk(clk), .i_rsn(rsn), .i_flush(hFlush), .i_valid(hValid), .o_ready(hOReady),
    .i_op1(hOp1), .i_op2(hOp2), .i_rm(hRm), .o_valid(hOValid), .i_ready(hIReady),
    .o_res(hRes), .o_flags(hFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAssert++;
    assert (obs === expv) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Push the expected outcome, then present the operands for exactly one accept edge
  task automatic applyStimulus(input bit half, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] mode, input logic [31:0] expRes,
                               input logic [4:0] expFlags, input int expLat, input string tag);
    exp_t e;
    e.res   = expRes;
    e.flags = expFlags;
    e.lat   = expLat;
    e.tag   = tag;
    sb.push_back(e);
    @(negedge clk);
    checkVal({tag, "_readyIn"}, 32'(half ? hOReady : oReady), 32'd1);
    if (half) begin
      hOp1 = a[15:0]; hOp2 = b[15:0]; hRm = mode; hValid = 1'b1;
    end else begin
      op1 = a; op2 = b; rm = mode; iValid = 1'b1;
    end
    @(posedge clk);
    #1;
    iValid = 1'b0;
    hValid = 1'b0;
  endtask

  task automatic checkOutput(input bit half);
    exp_t e;
    int   lat;
    logic v;
    e   = sb.pop_front();
    lat = 1;
    v   = half ? hOValid : oValid;
    while (!v && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      v = half ? hOValid : oValid;
    end
    checkVal({e.tag, "_valid"}, 32'(v), 32'd1);
    checkVal({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
    checkVal({e.tag, "_res"}, half ? {16'h0000, hRes} : oRes, e.res);
    checkVal({e.tag, "_flags"}, half ? 32'(hFlags) : 32'(oFlags), 32'(e.flags));
    if (half ? hIReady : iReady) begin
      @(posedge clk);
      #1;
      checkVal({e.tag, "_validDrop"}, 32'(half ? hOValid : oValid), 32'd0);
      checkVal({e.tag, "_readyBack"}, 32'(half ? hOReady : oReady), 32'd1);
    end
  endtask

  initial begin
    rsn = 1'b0; flush = 1'b0; iValid = 1'b0; iReady = 1'b1; op1 = '0; op2 = '0; rm = 2'd0;
    hFlush = 1'b0; hValid = 1'b0; hIReady = 1'b1; hOp1 = '0; hOp2 = '0; hRm = 2'd0;
    $display("[TB] fpu_div_seq directed run");
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_ready", 32'(oReady), 32'd1);
    checkVal("rst_valid", 32'(oValid), 32'd0);
    checkVal("rst_res", oRes, 32'd0);
    checkVal("rst_flags", 32'(oFlags), 32'd0);
    checkVal("rst_hReady", 32'(hOReady), 32'd1);
    @(negedge clk);
    rsn = 1'b1;

    applyStimulus(0, 32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 28, "div6by2");
    checkOutput(0);
    applyStimulus(0, 32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00001, 28, "thirdRne");
    checkOutput(0);
    applyStimulus(0, 32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA, 5'b00001, 28, "thirdRtz");
    checkOutput(0);
    applyStimulus(0, 32'h3F800000, 32'h40400000, 2'd3, 32'h3EAAAAAB, 5'b00001, 28, "thirdRup");
    checkOutput(0);
    applyStimulus(0, 32'hBF800000, 32'h40400000, 2'd2, 32'hBEAAAAAB, 5'b00001, 28, "negThirdRdn");
    checkOutput(0);
    applyStimulus(0, 32'hBF800000, 32'h40400000, 2'd3, 32'hBEAAAAAA, 5'b00001, 28, "negThirdRup");
    checkOutput(0);

    applyStimulus(0, 32'h3F800000, 32'h00000000, 2'd0, 32'h7F800000, 5'b01000, 1, "oneByZero");
    checkOutput(0);
    applyStimulus(0, 32'h00000000, 32'h00000000, 2'd0, 32'h7FC00000, 5'b10000, 1, "zeroByZero");
    checkOutput(0);
    applyStimulus(0, 32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b10000, 1, "nanOperand");
    checkOutput(0);
    applyStimulus(0, 32'hFF800000, 32'h7F800000, 2'd0, 32'h7FC00000, 5'b10000, 1, "infByInf");
    checkOutput(0);
    applyStimulus(0, 32'h7F800000, 32'hC0000000, 2'd0, 32'hFF800000, 5'b00000, 1, "infByFinite");
    checkOutput(0);
    applyStimulus(0, 32'h40000000, 32'h7F800000, 2'd0, 32'h00000000, 5'b00000, 1, "finiteByInf");
    checkOutput(0);
    applyStimulus(0, 32'h80000001, 32'h3F800000, 2'd0, 32'h80000000, 5'b00000, 1, "denormFlush");
    checkOutput(0);

    applyStimulus(0, 32'h7F000000, 32'h00800000, 2'd0, 32'h7F800000, 5'b00101, 28, "ovfRne");
    checkOutput(0);
    applyStimulus(0, 32'h7F000000, 32'h00800000, 2'd1, 32'h7F7FFFFF, 5'b00101, 28, "ovfRtz");
    checkOutput(0);
    applyStimulus(0, 32'h7F000000, 32'h00800000, 2'd2, 32'h7F7FFFFF, 5'b00101, 28, "ovfRdnPos");
    checkOutput(0);
    applyStimulus(0, 32'hFF000000, 32'h00800000, 2'd2, 32'hFF800000, 5'b00101, 28, "ovfRdnNeg");
    checkOutput(0);
    applyStimulus(0, 32'h00800000, 32'h40000000, 2'd0, 32'h00000000, 5'b00011, 28, "underflow");
    checkOutput(0);

    iReady = 1'b0;
    applyStimulus(0, 32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 28, "stall");
    checkOutput(0);
    repeat (10) begin
      @(posedge clk);
      #1;
      checkVal("stall_holdValid", 32'(oValid), 32'd1);
      checkVal("stall_holdReady", 32'(oReady), 32'd0);
      checkVal("stall_holdRes", oRes, 32'h40400000);
    end
    @(negedge clk);
    iReady = 1'b1;
    @(posedge clk);
    #1;
    checkVal("stall_releaseValid", 32'(oValid), 32'd0);
    checkVal("stall_releaseReady", 32'(oReady), 32'd1);

    applyStimulus(0, 32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 28, "flushed");
    dropped = sb.pop_front();
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkVal("flush_ready", 32'(oReady), 32'd1);
    checkVal("flush_valid", 32'(oValid), 32'd0);
    sawValid = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (oValid) sawValid = 1;
    end
    checkVal("flush_noValid", 32'(sawValid), 32'd0);
    applyStimulus(0, 32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00001, 28, "afterFlush");
    checkOutput(0);

    applyStimulus(0, 32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 28, "rstAbort");
    dropped = sb.pop_front();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rsn = 1'b0;
    #1;
    checkVal("midRst_ready", 32'(oReady), 32'd1);
    checkVal("midRst_valid", 32'(oValid), 32'd0);
    checkVal("midRst_res", oRes, 32'd0);
    checkVal("midRst_flags", 32'(oFlags), 32'd0);
    @(negedge clk);
    rsn = 1'b1;
    applyStimulus(0, 32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 28, "afterRst");
    checkOutput(0);

    applyStimulus(1, 32'h00004600, 32'h00004000, 2'd0, 32'h00004200, 5'b00000, 15, "halfDiv");
    checkOutput(1);
    applyStimulus(1, 32'h00003C00, 32'h00004200, 2'd0, 32'h00003555, 5'b00001, 15, "halfThird");
    checkOutput(1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
